// File: rtl/avalon_aes_regs.sv
// Avalon-MM register file for the AES decryption peripheral.
// The host loads the key and ciphertext, then sets START. A small control FSM sends a
// one-cycle launch pulse to the AES core together with a frozen snapshot of the key and
// ciphertext. It captures the plaintext when the core finishes, or flags a timeout if the
// core stays silent for TIMEOUT cycles. The host polls DONE and clears START to re-arm.
module avalon_aes_regs #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AVL_CS,
  input  logic         AVL_READ,
  input  logic         AVL_WRITE,
  input  logic [3:0]   AVL_ADDR,
  input  logic [3:0]   AVL_BYTE_EN,
  input  logic [31:0]  AVL_WRITEDATA,
  output logic [31:0]  AVL_READDATA,
  output logic [31:0]  EXPORT_DATA,
  output logic         CORE_START,
  output logic [127:0] CORE_KEY,
  output logic [127:0] CORE_MSG_IN,
  input  logic [127:0] CORE_MSG_OUT,
  input  logic         CORE_DONE
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_BUSY   = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  // Word registers 0..13. Words 8..11 hold the plaintext and are written only by the FSM.
  logic [13:0][31:0] regs_q, regs_d, regs_host;
  logic              start_q, start_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [127:0]      core_key_q, core_key_d;
  logic [127:0]      core_msg_in_q, core_msg_in_d;

  logic wr_en;
  logic rd_en;

  assign wr_en = AVL_CS & AVL_WRITE;
  assign rd_en = AVL_CS & AVL_READ;

  // Returns old_word with each byte enabled in be replaced by the matching byte of new_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // Words the host may write: key, ciphertext and the two spare words.
  function automatic logic is_host_rw(input int idx);
    return (idx < 8) || (idx == 12) || (idx == 13);
  endfunction

  // Host write path. Writes to the plaintext words and to DONE are dropped.
  always_comb begin
    regs_host = regs_q;
    start_d   = start_q;
    for (int i = 0; i < 14; i++) begin
      if (wr_en && (AVL_ADDR == 4'(i)) && is_host_rw(i)) begin
        regs_host[i] = byte_merge(regs_q[i], AVL_WRITEDATA, AVL_BYTE_EN);
      end
    end
    if (wr_en && (AVL_ADDR == 4'd14) && AVL_BYTE_EN[0]) begin
      start_d = AVL_WRITEDATA[0];
    end
  end

  // Control FSM. The plaintext capture is applied after the host path so the capture wins.
  always_comb begin
    state_d       = state_q;
    done_d        = done_q;
    cnt_d         = cnt_q;
    core_key_d    = core_key_q;
    core_msg_in_d = core_msg_in_q;
    regs_d        = regs_host;
    case (state_q)
      ST_IDLE: begin
        done_d = 2'b00;
        if (start_q) begin
          state_d       = ST_LAUNCH;
          core_key_d    = {regs_q[0], regs_q[1], regs_q[2], regs_q[3]};
          core_msg_in_d = {regs_q[4], regs_q[5], regs_q[6], regs_q[7]};
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (CORE_DONE) begin
          regs_d[8]  = CORE_MSG_OUT[127:96];
          regs_d[9]  = CORE_MSG_OUT[95:64];
          regs_d[10] = CORE_MSG_OUT[63:32];
          regs_d[11] = CORE_MSG_OUT[31:0];
          done_d     = 2'b01;
          state_d    = ST_HOLD;
        end else if (cnt_q == LAST_CNT) begin
          done_d  = 2'b11;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!start_q) begin
          done_d  = 2'b00;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Combinational read mux (zero read latency); the bus reads zero when not selected.
  always_comb begin
    AVL_READDATA = 32'h0;
    if (rd_en) begin
      for (int i = 0; i < 14; i++) begin
        if (AVL_ADDR == 4'(i)) AVL_READDATA = regs_q[i];
      end
      if (AVL_ADDR == 4'd14) AVL_READDATA = {31'h0, start_q};
      if (AVL_ADDR == 4'd15) AVL_READDATA = {30'h0, done_q};
    end
  end

  // State registers with synchronous reset; a reset mid-run simply abandons the run.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      regs_q        <= '0;
      start_q       <= 1'b0;
      done_q        <= 2'b00;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      core_key_q    <= '0;
      core_msg_in_q <= '0;
    end else begin
      regs_q        <= regs_d;
      start_q       <= start_d;
      done_q        <= done_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      core_key_q    <= core_key_d;
      core_msg_in_q <= core_msg_in_d;
    end
  end

  assign CORE_START  = (state_q == ST_LAUNCH);
  assign CORE_KEY    = core_key_q;
  assign CORE_MSG_IN = core_msg_in_q;
  assign EXPORT_DATA = {regs_q[0][31:16], regs_q[3][15:0]};

endmodule

// File: tb/tb_avalon_aes_regs.sv
// Testbench for avalon_aes_regs. It keeps a word-level model of the host-visible
// registers and predicts run outcomes from the timing rules: the launch pulse, the
// done-or-timeout latency and the captured plaintext.
module tb_avalon_aes_regs;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         AVL_CS, AVL_READ, AVL_WRITE;
  logic [3:0]   AVL_ADDR, AVL_BYTE_EN;
  logic [31:0]  AVL_WRITEDATA, AVL_READDATA, EXPORT_DATA;
  logic         CORE_START, CORE_DONE;
  logic [127:0] CORE_KEY, CORE_MSG_IN, CORE_MSG_OUT;

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [16];

  avalon_aes_regs #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .AVL_CS(AVL_CS), .AVL_READ(AVL_READ),
    .AVL_WRITE(AVL_WRITE), .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .EXPORT_DATA(EXPORT_DATA), .CORE_START(CORE_START), .CORE_KEY(CORE_KEY),
    .CORE_MSG_IN(CORE_MSG_IN), .CORE_MSG_OUT(CORE_MSG_OUT), .CORE_DONE(CORE_DONE)
  );

  always #5 CLK = ~CLK;

  // Model of a host write: byte-wise update of RW words, START keeps bit0 only.
  function automatic void modelWrite(input logic [3:0] addr, input logic [31:0] data,
                                     input logic [3:0] be);
    int a;
    a = int'(addr);
    if (a < 8 || a == 12 || a == 13) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mdl[a][8*b +: 8] = data[8*b +: 8];
      end
    end else if (a == 14 && be[0]) begin
      mdl[14] = {31'h0, data[0]};
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic busIdle();
    AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    AVL_ADDR = 4'h0; AVL_BYTE_EN = 4'h0; AVL_WRITEDATA = 32'h0;
  endtask

  // One host write cycle, issued from a negedge; returns on the following negedge.
  task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data,
                               input logic [3:0] be);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_READ = 1'b0;
    AVL_ADDR = addr; AVL_WRITEDATA = data; AVL_BYTE_EN = be;
    @(posedge CLK);
    @(negedge CLK);
    busIdle();
    modelWrite(addr, data, be);
  endtask

  // Zero-latency read sampled mid low phase; returns on the next negedge.
  task automatic readReg(input logic [3:0] addr, output logic [31:0] data);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b0; AVL_ADDR = addr;
    #1;
    data = AVL_READDATA;
    busIdle();
    @(negedge CLK);
  endtask

  task automatic sweepRegs(input string tag);
    logic [31:0] d;
    for (int i = 0; i < 16; i++) begin
      readReg(4'(i), d);
      checkOutput($sformatf("%s_r%0d", tag, i), 128'(d), 128'(mdl[i]));
    end
    checkOutput({tag, "_export"}, 128'(EXPORT_DATA), 128'({mdl[0][31:16], mdl[3][15:0]}));
  endtask

  // Sets START and watches the run while polling DONE. A core model raises CORE_DONE
  // 'delay' cycles after the launch pulse (delay<1 means never), and the host
  // optionally rewrites key word 0 'rewrite_at' cycles after the pulse.
  task automatic runOp(input int delay, input int rewrite_at, input logic [31:0] newKey0,
                       input logic [127:0] msgOut, output int pulses, output int c0,
                       output int doneIter, output logic [31:0] doneWord,
                       output logic [127:0] keyAtPulse, output logic [127:0] msgAtPulse,
                       output logic [127:0] keyEnd);
    logic wasWrite;
    pulses = 0; c0 = -1; doneIter = -1; doneWord = 32'h0;
    keyAtPulse = '0; msgAtPulse = '0;
    CORE_MSG_OUT = msgOut;
    CORE_DONE = 1'b0;
    applyStimulus(4'd14, 32'h1, 4'hF);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = 4'd15;
    wasWrite = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (CORE_START === 1'b1) begin
        if (pulses == 0) begin
          c0 = i; keyAtPulse = CORE_KEY; msgAtPulse = CORE_MSG_IN;
        end
        pulses++;
      end
      if (!wasWrite && doneIter < 0 && AVL_READDATA !== 32'h0) begin
        doneIter = i; doneWord = AVL_READDATA;
      end
      CORE_DONE = (c0 >= 0 && delay >= 1 && i >= c0 + delay && i < c0 + delay + 3);
      if (c0 >= 0 && rewrite_at >= 0 && i == c0 + rewrite_at) begin
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_READ = 1'b0; AVL_ADDR = 4'd0;
        AVL_WRITEDATA = newKey0; AVL_BYTE_EN = 4'hF;
        modelWrite(4'd0, newKey0, 4'hF);
        wasWrite = 1'b1;
      end else begin
        AVL_CS = 1'b1; AVL_WRITE = 1'b0; AVL_READ = 1'b1; AVL_ADDR = 4'd15;
        AVL_BYTE_EN = 4'h0; AVL_WRITEDATA = 32'h0;
        wasWrite = 1'b0;
      end
    end
    keyEnd = CORE_KEY;
    CORE_DONE = 1'b0;
    busIdle();
  endtask

  // Full run with predicted outcome: completion after 'delay' BUSY cycles, or a timeout
  // after TIMEOUT cycles, whichever comes first (completion wins a tie).
  task automatic doRun(input string tag, input int delay, input int rewrite_at,
                       input logic [127:0] msgOut);
    logic [127:0] expKey, expMsg, keyAtPulse, msgAtPulse, keyEnd;
    logic [31:0]  doneWord, d;
    int pulses, c0, doneIter, eff;
    bit finishes;
    expKey = {mdl[0], mdl[1], mdl[2], mdl[3]};
    expMsg = {mdl[4], mdl[5], mdl[6], mdl[7]};
    finishes = (delay >= 1 && delay <= TIMEOUT);
    eff = finishes ? delay : TIMEOUT;
    runOp(delay, rewrite_at, $urandom, msgOut, pulses, c0, doneIter, doneWord,
          keyAtPulse, msgAtPulse, keyEnd);
    checkOutput({tag, "_start_pulses"}, 128'(pulses), 128'(1));
    checkOutput({tag, "_core_key"}, keyAtPulse, expKey);
    checkOutput({tag, "_core_msg_in"}, msgAtPulse, expMsg);
    checkOutput({tag, "_core_key_held"}, keyEnd, expKey);
    checkOutput({tag, "_done_cycle"}, 128'(doneIter), 128'(c0 + 1 + eff));
    checkOutput({tag, "_done_word"}, 128'(doneWord), finishes ? 128'(1) : 128'(3));
    if (finishes) begin
      mdl[8] = msgOut[127:96]; mdl[9] = msgOut[95:64];
      mdl[10] = msgOut[63:32]; mdl[11] = msgOut[31:0];
    end
    mdl[15] = finishes ? 32'h1 : 32'h3;
    readReg(4'd0, d);
    checkOutput({tag, "_reg0"}, 128'(d), 128'(mdl[0]));
    for (int i = 8; i < 12; i++) begin
      readReg(4'(i), d);
      checkOutput($sformatf("%s_msg_de%0d", tag, i), 128'(d), 128'(mdl[i]));
    end
    applyStimulus(4'd14, 32'h0, 4'hF);
    readReg(4'd15, d);
    checkOutput({tag, "_done_after_clear"}, 128'(d), 128'(mdl[15]));
    mdl[15] = 32'h0;
    readReg(4'd15, d);
    checkOutput({tag, "_done_cleared"}, 128'(d), 128'(mdl[15]));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  a;
    RESET = 1'b1;
    CORE_DONE = 1'b0;
    CORE_MSG_OUT = '0;
    busIdle();
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;

    $display("[TB] reset state");
    sweepRegs("reset");
    checkOutput("reset_core_start", 128'(CORE_START), 128'(0));
    checkOutput("reset_core_key", CORE_KEY, 128'(0));

    $display("[TB] byte enables and read-only words");
    applyStimulus(4'd2, 32'hDEADBEEF, 4'b0101);
    readReg(4'd2, d);
    checkOutput("reg2_byte_en", 128'(d), 128'(32'h00AD00EF));
    checkOutput("reg2_model", 128'(d), 128'(mdl[2]));
    applyStimulus(4'd9, 32'h1, 4'hF);
    readReg(4'd9, d);
    checkOutput("reg9_read_only", 128'(d), 128'(0));

    $display("[TB] random host writes");
    for (int n = 0; n < 30; n++) begin
      a = 4'($urandom_range(0, 15));
      if (a == 4'd14) a = 4'd13;
      applyStimulus(a, $urandom, 4'($urandom_range(0, 15)));
    end
    sweepRegs("random");

    $display("[TB] known-answer run");
    applyStimulus(4'd0, 32'h00010203, 4'hF);
    applyStimulus(4'd1, 32'h04050607, 4'hF);
    applyStimulus(4'd2, 32'h08090A0B, 4'hF);
    applyStimulus(4'd3, 32'h0C0D0E0F, 4'hF);
    for (int i = 4; i < 8; i++) applyStimulus(4'(i), $urandom, 4'hF);
    doRun("kat", 10, -1, 128'h3925841D02DC09FBDC118597196A0B32);
    readReg(4'd8, d);
    checkOutput("kat_reg8", 128'(d), 128'(32'h3925841D));

    $display("[TB] timeout with key rewrite during busy");
    doRun("timeout", -1, 3, {$urandom, $urandom, $urandom, $urandom});

    $display("[TB] done and timeout coincide");
    doRun("tie", TIMEOUT, -1, {$urandom, $urandom, $urandom, $urandom});

    $display("[TB] random runs");
    for (int n = 0; n < 4; n++) begin
      doRun($sformatf("rnd%0d", n), $urandom_range(1, TIMEOUT + 4), -1,
            {$urandom, $urandom, $urandom, $urandom});
    end

    $display("[TB] reset during busy");
    applyStimulus(4'd14, 32'h1, 4'hF);
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    CORE_DONE = 1'b1;
    CORE_MSG_OUT = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    checkOutput("rst_busy_core_start", 128'(CORE_START), 128'(0));
    readReg(4'd15, d);
    checkOutput("rst_busy_done", 128'(d), 128'(0));
    repeat (3) @(negedge CLK);
    CORE_DONE = 1'b0;
    sweepRegs("rst_busy");
    checkOutput("rst_busy_core_key", CORE_KEY, 128'(0));
    checkOutput("rst_busy_core_msg_in", CORE_MSG_IN, 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
